hlsm_job_driver: RTL and testbench

//  Initiator for the HLS-generated HLSM core: accepts an operand job on a valid/ready port, holds the

---
 rtl/hlsm_job_driver_if.sv | 35 +++
 rtl/hlsm_job_driver.sv | 126 ++++++++++++
 tb/tb_hlsm_job_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hlsm_job_driver_if.sv
// Bundle of job, core and result signals between the HLSM job driver and its environment.
// master is the driver side; slave is the job source, core and result consumer side.
interface hlsm_job_driver_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OPS = 12
);
  logic                        job_valid;
  logic                        job_ready;
  logic [NUM_OPS*DATA_W-1:0]   job_ops;
  logic [NUM_OPS*DATA_W-1:0]   hlsm_ops;
  logic                        hlsm_start;
  logic                        hlsm_rst;
  logic                        hlsm_done;
  logic [DATA_W-1:0]           hlsm_w;
  logic                        res_valid;
  logic                        res_ready;
  logic [DATA_W-1:0]           res_data;
  logic                        res_timeout;
  logic                        busy;
  logic                        err_spurious;
  logic [15:0]                 job_cnt;
  logic [7:0]                  tmo_cnt;

  modport master (
    input  job_valid, job_ops, hlsm_done, hlsm_w, res_ready,
    output job_ready, hlsm_ops, hlsm_start, hlsm_rst, res_valid, res_data, res_timeout,
           busy, err_spurious, job_cnt, tmo_cnt
  );

  modport slave (
    output job_valid, job_ops, hlsm_done, hlsm_w, res_ready,
    input  job_ready, hlsm_ops, hlsm_start, hlsm_rst, res_valid, res_data, res_timeout,
           busy, err_spurious, job_cnt, tmo_cnt
  );
endinterface

// File: rtl/hlsm_job_driver.sv
// Drives one job at a time into the HLSM core: hold operands, pulse Start, wait for Done,
// return W on the result port; a watchdog resets a hung core and reports a timeout.
module hlsm_job_driver #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OPS = 12,
  parameter int unsigned TMO_CYC = 1024
) (
  input logic                  Clk,
  input logic                  Rst,
  hlsm_job_driver_if.master    bus
);

  localparam int unsigned TimerW = $clog2(TMO_CYC) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TMO_CYC - 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StRecov, StResp} state_e;

  state_e                    state_q, state_d;
  logic [NUM_OPS*DATA_W-1:0] hlsm_ops_q, hlsm_ops_d;
  logic                      hlsm_start_q, hlsm_start_d;
  logic                      hlsm_rst_q, hlsm_rst_d;
  logic [TimerW-1:0]         timer_q, timer_d;
  logic                      res_valid_q, res_valid_d;
  logic [DATA_W-1:0]         res_data_q, res_data_d;
  logic                      res_timeout_q, res_timeout_d;
  logic                      err_spurious_q, err_spurious_d;
  logic [15:0]               job_cnt_q, job_cnt_d;
  logic [7:0]                tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    state_d        = state_q;
    hlsm_ops_d     = hlsm_ops_q;
    hlsm_start_d   = 1'b0;
    hlsm_rst_d     = 1'b0;
    timer_d        = timer_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_timeout_d  = res_timeout_q;
    // Done outside the wait window is flagged and otherwise ignored.
    err_spurious_d = err_spurious_q | (bus.hlsm_done && (state_q != StWait));
    job_cnt_d      = job_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.job_valid) begin
          hlsm_ops_d   = bus.job_ops;
          hlsm_start_d = 1'b1;
          timer_d      = '0;
          state_d      = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        // Done takes priority over an expiring watchdog in the same cycle.
        if (bus.hlsm_done) begin
          res_data_d    = bus.hlsm_w;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = StResp;
        end else if (timer_q == TimerLast) begin
          hlsm_rst_d    = 1'b1;
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = StRecov;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRecov: begin
        res_valid_d = 1'b1;
        if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        state_d = StResp;
      end
      StResp: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          job_cnt_d   = job_cnt_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= StIdle;
      hlsm_ops_q     <= '0;
      hlsm_start_q   <= 1'b0;
      hlsm_rst_q     <= 1'b1;
      timer_q        <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      job_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      hlsm_ops_q     <= hlsm_ops_d;
      hlsm_start_q   <= hlsm_start_d;
      hlsm_rst_q     <= hlsm_rst_d;
      timer_q        <= timer_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_timeout_q  <= res_timeout_d;
      err_spurious_q <= err_spurious_d;
      job_cnt_q      <= job_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign bus.job_ready    = (state_q == StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.hlsm_ops     = hlsm_ops_q;
  assign bus.hlsm_start   = hlsm_start_q;
  assign bus.hlsm_rst     = hlsm_rst_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_timeout  = res_timeout_q;
  assign bus.err_spurious = err_spurious_q;
  assign bus.job_cnt      = job_cnt_q;
  assign bus.tmo_cnt      = tmo_cnt_q;

endmodule

// File: tb/tb_hlsm_job_driver.sv
// Directed bench for hlsm_job_driver with a 16-cycle watchdog; the core is modelled by
// driving hlsm_done/hlsm_w by hand. Inputs change and outputs are sampled on the falling edge.
module tb_hlsm_job_driver;

  localparam int unsigned DataW = 32;
  localparam int unsigned NumOps = 12;
  localparam int unsigned OpsW = DataW * NumOps;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  hlsm_job_driver_if #(.DATA_W(DataW), .NUM_OPS(NumOps)) bus ();

  hlsm_job_driver #(.DATA_W(DataW), .NUM_OPS(NumOps), .TMO_CYC(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  function automatic logic [OpsW-1:0] mk_ops(input int seed);
    logic [OpsW-1:0] o;
    for (int k = 0; k < int'(NumOps); k++) o[k*DataW +: DataW] = DataW'(seed * 16 + k);
    return o;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  // Present a job for one edge; afterwards the driver is in its Start cycle.
  task automatic offer(input logic [OpsW-1:0] ops);
    bus.job_ops   = ops;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [DataW-1:0] w);
    bus.hlsm_done = 1'b1;
    bus.hlsm_w    = w;
    step();
    bus.hlsm_done = 1'b0;
    bus.hlsm_w    = '0;
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(3);
    checks++; if (bus.hlsm_rst !== 1'b1) begin errors++; $display("FAIL rst_hlsm_rst got %b want 1", bus.hlsm_rst); end
    checks++; if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle got ready=%b busy=%b want 1/0", bus.job_ready, bus.busy); end
    checks++; if (bus.hlsm_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_timeout !== 1'b0) begin errors++; $display("FAIL rst_flags got start=%b valid=%b tmo=%b want 0", bus.hlsm_start, bus.res_valid, bus.res_timeout); end
    checks++; if (bus.job_cnt !== 16'd0 || bus.tmo_cnt !== 8'd0 || bus.err_spurious !== 1'b0) begin errors++; $display("FAIL rst_counters got %0d/%0d/%b want 0", bus.job_cnt, bus.tmo_cnt, bus.err_spurious); end
    checks++; if (bus.hlsm_ops !== '0 || bus.res_data !== '0) begin errors++; $display("FAIL rst_data got ops=%0h data=%0h want 0", bus.hlsm_ops, bus.res_data); end
    Rst = 1'b0;
    checks++; if (bus.hlsm_rst !== 1'b1) begin errors++; $display("FAIL rst_release_hold got %b want 1", bus.hlsm_rst); end
    step();
    checks++; if (bus.hlsm_rst !== 1'b0) begin errors++; $display("FAIL rst_release got %b want 0", bus.hlsm_rst); end
  endtask

  task automatic test_basic();
    logic [OpsW-1:0] ops;
    int starts;
    ops = '0;
    ops[0*DataW +: DataW] = 32'd5;
    ops[1*DataW +: DataW] = 32'd7;
    offer(ops);
    checks++; if (bus.hlsm_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b want 1", bus.hlsm_start); end
    checks++; if (bus.hlsm_ops !== ops) begin errors++; $display("FAIL basic_ops got %0h want %0h", bus.hlsm_ops, ops); end
    checks++; if (bus.job_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got ready=%b busy=%b want 0/1", bus.job_ready, bus.busy); end
    starts = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.hlsm_start === 1'b1) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL basic_start_width got %0d extra start cycles want 0", starts); end
    pulse_done(32'd12);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd12 || bus.res_timeout !== 1'b0) begin errors++; $display("FAIL basic_result got v=%b d=%0d t=%b want 1/12/0", bus.res_valid, bus.res_data, bus.res_timeout); end
    checks++; if (bus.job_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt_early got %0d want 0", bus.job_cnt); end
    take();
    checks++; if (bus.res_valid !== 1'b0 || bus.job_cnt !== 16'd1 || bus.job_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got v=%b cnt=%0d rdy=%b want 0/1/1", bus.res_valid, bus.job_cnt, bus.job_ready); end
  endtask

  task automatic test_back_to_back();
    int bad;
    offer(mk_ops(2));
    step();
    pulse_done(32'hABCD);
    bus.job_ops   = mk_ops(3);
    bus.job_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hABCD || bus.job_ready !== 1'b0 ||
          bus.hlsm_start !== 1'b0 || bus.hlsm_ops !== mk_ops(2)) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.job_cnt !== 16'd2 || bus.hlsm_start !== 1'b0) begin errors++; $display("FAIL bp_handshake got v=%b cnt=%0d start=%b want 0/2/0", bus.res_valid, bus.job_cnt, bus.hlsm_start); end
    step();
    bus.job_valid = 1'b0;
    checks++; if (bus.hlsm_start !== 1'b1 || bus.hlsm_ops !== mk_ops(3)) begin errors++; $display("FAIL bp_second_accept got start=%b ops=%0h want 1/%0h", bus.hlsm_start, bus.hlsm_ops, mk_ops(3)); end
    step(2);
    pulse_done(32'h3);
    take();
    checks++; if (bus.job_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt got %0d want 3", bus.job_cnt); end
  endtask

  task automatic test_timeout();
    int bad;
    offer(mk_ops(4));
    step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.hlsm_rst !== 1'b0 || bus.res_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tmo_early got %0d bad cycles want 0", bad); end
    checks++; if (bus.hlsm_rst !== 1'b1 || bus.res_valid !== 1'b0 || bus.tmo_cnt !== 8'd0) begin errors++; $display("FAIL tmo_recov got rst=%b v=%b cnt=%0d want 1/0/0", bus.hlsm_rst, bus.res_valid, bus.tmo_cnt); end
    step();
    checks++; if (bus.hlsm_rst !== 1'b0 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL tmo_resp got rst=%b v=%b want 0/1", bus.hlsm_rst, bus.res_valid); end
    checks++; if (bus.res_timeout !== 1'b1 || bus.res_data !== 32'd0 || bus.tmo_cnt !== 8'd1) begin errors++; $display("FAIL tmo_result got t=%b d=%0h cnt=%0d want 1/0/1", bus.res_timeout, bus.res_data, bus.tmo_cnt); end
    take();
    checks++; if (bus.job_cnt !== 16'd4) begin errors++; $display("FAIL tmo_cnt_jobs got %0d want 4", bus.job_cnt); end
  endtask

  task automatic test_race();
    offer(mk_ops(5));
    step(16);
    pulse_done(32'h55);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_timeout !== 1'b0 || bus.res_data !== 32'h55) begin errors++; $display("FAIL race_result got v=%b t=%b d=%0h want 1/0/55", bus.res_valid, bus.res_timeout, bus.res_data); end
    checks++; if (bus.hlsm_rst !== 1'b0 || bus.tmo_cnt !== 8'd1) begin errors++; $display("FAIL race_no_recov got rst=%b tmo=%0d want 0/1", bus.hlsm_rst, bus.tmo_cnt); end
    take();
  endtask

  task automatic test_spurious();
    pulse_done(32'hDEAD);
    checks++; if (bus.err_spurious !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL spur_flag got e=%b v=%b busy=%b want 1/0/0", bus.err_spurious, bus.res_valid, bus.busy); end
    offer(mk_ops(6));
    step(3);
    pulse_done(32'h99);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h99 || bus.err_spurious !== 1'b1) begin errors++; $display("FAIL spur_next_job got v=%b d=%0h e=%b want 1/99/1", bus.res_valid, bus.res_data, bus.err_spurious); end
    take();
    checks++; if (bus.job_cnt !== 16'd6) begin errors++; $display("FAIL spur_cnt got %0d want 6", bus.job_cnt); end
  endtask

  task automatic test_reset_mid();
    int bad;
    offer(mk_ops(7));
    step(3);
    Rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.res_valid !== 1'b0 || bus.hlsm_rst !== 1'b1 || bus.job_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_hold got %0d bad cycles want 0", bad); end
    Rst = 1'b0;
    checks++; if (bus.hlsm_rst !== 1'b1 || bus.job_cnt !== 16'd0 || bus.hlsm_ops !== '0) begin errors++; $display("FAIL midrst_state got rst=%b cnt=%0d ops=%0h want 1/0/0", bus.hlsm_rst, bus.job_cnt, bus.hlsm_ops); end
    step();
    checks++; if (bus.hlsm_rst !== 1'b0 || bus.job_ready !== 1'b1 || bus.err_spurious !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got rst=%b rdy=%b e=%b v=%b want 0/1/0/0", bus.hlsm_rst, bus.job_ready, bus.err_spurious, bus.res_valid); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      offer(mk_ops(i + 8));
      step();
      pulse_done(DataW'(i + 1));
      if (bus.res_valid !== 1'b1 || bus.res_data !== DataW'(i + 1)) bad++;
      take();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_results got %0d bad results want 0", bad); end
    checks++; if (bus.job_cnt !== 16'd100 || bus.tmo_cnt !== 8'd0) begin errors++; $display("FAIL b2b_counts got job=%0d tmo=%0d want 100/0", bus.job_cnt, bus.tmo_cnt); end
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_ops   = '0;
    bus.hlsm_done = 1'b0;
    bus.hlsm_w    = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_race();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
